// File: rtl/mem_access_unit_pkg.sv
// Shared types and constants for the data-memory access unit.
// Holds FSM encoding, funct3 size codes and the request legality check.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WB   = 2'd2,
    ERR  = 2'd3
  } mem_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // High when the request must be rejected without touching memory.
  function automatic logic access_fault(input logic       rd,
                                        input logic       wr,
                                        input logic [2:0] f3,
                                        input logic [1:0] off);
    logic bad;
    bad = 1'b0;
    if (rd == wr) begin
      bad = 1'b1;
    end else if (wr && (f3[2] || (f3 == 3'b011))) begin
      bad = 1'b1;
    end else if (rd && ((f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111))) begin
      bad = 1'b1;
    end else if ((f3[1:0] == 2'b01) && off[0]) begin
      bad = 1'b1;
    end else if ((f3 == F3_W) && (off != 2'b00)) begin
      bad = 1'b1;
    end else begin
      bad = 1'b0;
    end
    return bad;
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Word-wide data-memory request/ready bus between the access unit and memory.
interface mem_bus_if #(
  parameter int D_WIDTH = 32
);
  logic               mem_req;
  logic               mem_we;
  logic [D_WIDTH-1:0] mem_addr;
  logic [D_WIDTH-1:0] mem_wdata;
  logic [3:0]         mem_wstrb;
  logic               mem_ready;
  logic [D_WIDTH-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/mem_access_unit_load_formatter.sv
// Selects the addressed byte/half of a read word and sign/zero extends it.
module load_formatter
  import mem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic [31:0] rdata,
  output logic [31:0] result
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  assign byte_s = rdata[{off, 3'b000} +: 8];
  assign half_s = rdata[{off[1], 4'b0000} +: 16];

  always_comb begin
    result = 32'h0000_0000;
    case (funct3)
      F3_B:    result = {{24{byte_s[7]}}, byte_s};
      F3_H:    result = {{16{half_s[15]}}, half_s};
      F3_W:    result = rdata;
      F3_BU:   result = {24'h00_0000, byte_s};
      F3_HU:   result = {16'h0000, half_s};
      default: result = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Multi-cycle RV32I load/store unit: one memory transaction per start,
// with lane steering, strobes, load formatting and fault detection.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int A_WIDTH = 5,
  parameter int D_WIDTH = 32
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               start,
  input  logic               MemRead,
  input  logic               MemWrite,
  input  logic [2:0]         funct3,
  input  logic [D_WIDTH-1:0] ALUResult,
  input  logic [D_WIDTH-1:0] RD2,
  input  logic [A_WIDTH-1:0] A3_in,
  output logic               busy,
  output logic               done,
  output logic               misaligned,
  mem_bus_if.master          bus,
  output logic [D_WIDTH-1:0] Result,
  output logic               RegWrite,
  output logic [A_WIDTH-1:0] A3
);

  mem_state_t         state_q, state_d;
  logic [D_WIDTH-1:0] addr_q;
  logic [1:0]         off_q;
  logic [2:0]         f3_q;
  logic               we_q;
  logic [D_WIDTH-1:0] wdata_q, wdata_s;
  logic [3:0]         wstrb_q, wstrb_s;
  logic [A_WIDTH-1:0] a3_q;
  logic [D_WIDTH-1:0] result_q, fmt_s;
  logic               capture_s;

  assign capture_s = (state_q == IDLE) && start;

  // Next-state selection; faults are resolved at issue so memory is never touched.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = access_fault(MemRead, MemWrite, funct3, ALUResult[1:0]) ? ERR : REQ;
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        if (bus.mem_ready) begin
          state_d = WB;
        end else begin
          state_d = REQ;
        end
      end
      WB:      state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Store lane replication and byte enables; loads drive no strobes.
  always_comb begin
    wdata_s = '0;
    wstrb_s = 4'b0000;
    if (MemWrite) begin
      case (funct3)
        F3_B: begin
          wdata_s = {4{RD2[7:0]}};
          wstrb_s = 4'b0001 << ALUResult[1:0];
        end
        F3_H: begin
          wdata_s = {2{RD2[15:0]}};
          wstrb_s = 4'b0011 << ALUResult[1:0];
        end
        F3_W: begin
          wdata_s = RD2;
          wstrb_s = 4'hF;
        end
        default: begin
          wdata_s = '0;
          wstrb_s = 4'b0000;
        end
      endcase
    end else begin
      wdata_s = '0;
      wstrb_s = 4'b0000;
    end
  end

  load_formatter u_load_formatter (
    .funct3 (f3_q),
    .off    (off_q),
    .rdata  (bus.mem_rdata),
    .result (fmt_s)
  );

  // State, request capture and load-data capture.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      off_q    <= 2'b00;
      f3_q     <= 3'b000;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      wstrb_q  <= 4'b0000;
      a3_q     <= '0;
      result_q <= '0;
    end else begin
      state_q <= state_d;
      if (capture_s) begin
        addr_q  <= {ALUResult[D_WIDTH-1:2], 2'b00};
        off_q   <= ALUResult[1:0];
        f3_q    <= funct3;
        we_q    <= MemWrite;
        wdata_q <= wdata_s;
        wstrb_q <= wstrb_s;
        a3_q    <= A3_in;
      end
      if ((state_q == REQ) && bus.mem_ready && !we_q) begin
        result_q <= fmt_s;
      end
    end
  end

  assign busy          = (state_q != IDLE);
  assign done          = (state_q == WB) || (state_q == ERR);
  assign misaligned    = (state_q == ERR);
  assign bus.mem_req   = (state_q == REQ);
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_wstrb = wstrb_q;
  assign Result        = result_q;
  assign RegWrite      = (state_q == WB) && !we_q && (a3_q != '0);
  assign A3            = a3_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed table-driven bench for mem_access_unit with a behavioural memory responder.
module tb_mem_access_unit;
  import mem_pkg::*;

  logic        CLK = 1'b0;
  logic        RST, start, MemRead, MemWrite;
  logic [2:0]  funct3;
  logic [31:0] ALUResult, RD2, Result;
  logic [4:0]  A3_in, A3_o;
  logic        busy, done, misaligned, RegWrite;

  mem_bus_if #(.D_WIDTH(32)) bus ();

  mem_access_unit #(.A_WIDTH(5), .D_WIDTH(32)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .start      (start),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .funct3     (funct3),
    .ALUResult  (ALUResult),
    .RD2        (RD2),
    .A3_in      (A3_in),
    .busy       (busy),
    .done       (done),
    .misaligned (misaligned),
    .bus        (bus),
    .Result     (Result),
    .RegWrite   (RegWrite),
    .A3         (A3_o)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] rd2;
    logic [31:0] rdata;
    logic [4:0]  a3;
    logic        exp_err;
    logic [3:0]  exp_strb;
    logic [31:0] exp_wdata;
    logic [31:0] exp_res;
    logic        exp_rw;
  } vec_t;

  vec_t        vecs[17];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] last_res;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one request at a negedge, service it with dly wait cycles, and check completion.
  task automatic run_vec(input vec_t v, input int dly, input bit poke_start);
    int cyc;
    int req_cnt;
    start      = 1'b1;
    MemRead    = v.rd;
    MemWrite   = v.wr;
    funct3     = v.f3;
    ALUResult  = v.addr;
    RD2        = v.rd2;
    A3_in      = v.a3;
    bus.mem_rdata = v.rdata;
    bus.mem_ready = 1'b0;
    @(negedge CLK);
    start = 1'b0;
    cyc = 1;
    req_cnt = 0;
    chk("busy_after_issue", {31'd0, busy}, 32'd1);
    while (!done && cyc < 40) begin
      if (bus.mem_req) begin
        req_cnt++;
        chk("mem_addr", bus.mem_addr, {v.addr[31:2], 2'b00});
        chk("mem_we", {31'd0, bus.mem_we}, {31'd0, v.wr});
        chk("mem_wstrb", {28'd0, bus.mem_wstrb}, {28'd0, v.exp_strb});
        chk("mem_wdata", bus.mem_wdata, v.exp_wdata);
      end
      bus.mem_ready = bus.mem_req && (req_cnt > dly);
      if (poke_start && cyc == 2) begin
        start = 1'b1;
        ALUResult = 32'h0000_0F00;
      end else begin
        start = 1'b0;
      end
      @(negedge CLK);
      cyc++;
    end
    start = 1'b0;
    chk("done_seen", {31'd0, done}, 32'd1);
    chk("done_cycle", cyc, v.exp_err ? 32'd1 : 32'(2 + dly));
    chk("req_cycles", req_cnt, v.exp_err ? 32'd0 : 32'(dly + 1));
    chk("misaligned", {31'd0, misaligned}, {31'd0, v.exp_err});
    chk("RegWrite", {31'd0, RegWrite}, {31'd0, v.exp_rw});
    if (v.rd && !v.wr && !v.exp_err) begin
      last_res = v.exp_res;
      chk("A3", {27'd0, A3_o}, {27'd0, v.a3});
    end
    chk("Result", Result, last_res);
    bus.mem_ready = 1'b0;
    @(negedge CLK);
    chk("done_pulse_end", {31'd0, done}, 32'd0);
    chk("idle_after_done", {30'd0, busy, bus.mem_req}, 32'd0);
  endtask

  initial begin
    //          rd    wr    f3      addr          rd2           rdata         a3    err   strb    wdata         res           rw
    vecs[0]  = '{1'b0, 1'b1, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0,        5'd0, 1'b0, 4'hF,   32'hDEAD_BEEF, 32'h0,        1'b0};
    vecs[1]  = '{1'b0, 1'b1, 3'b000, 32'h0000_0103, 32'h0000_00A5, 32'h0,        5'd0, 1'b0, 4'b1000, 32'hA5A5_A5A5, 32'h0,       1'b0};
    vecs[2]  = '{1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h0,         32'hA500_0000, 5'd7, 1'b0, 4'h0,   32'h0,         32'hFFFF_FFA5, 1'b1};
    vecs[3]  = '{1'b1, 1'b0, 3'b100, 32'h0000_0103, 32'h0,         32'hA500_0000, 5'd7, 1'b0, 4'h0,   32'h0,         32'h0000_00A5, 1'b1};
    vecs[4]  = '{1'b1, 1'b0, 3'b001, 32'h0000_0202, 32'h0,         32'h8001_1234, 5'd5, 1'b0, 4'h0,   32'h0,         32'hFFFF_8001, 1'b1};
    vecs[5]  = '{1'b1, 1'b0, 3'b101, 32'h0000_0202, 32'h0,         32'h8001_1234, 5'd5, 1'b0, 4'h0,   32'h0,         32'h0000_8001, 1'b1};
    vecs[6]  = '{1'b1, 1'b0, 3'b010, 32'h0000_0302, 32'h0,         32'h0,         5'd3, 1'b1, 4'h0,   32'h0,         32'h0,         1'b0};
    vecs[7]  = '{1'b1, 1'b0, 3'b010, 32'h0000_0300, 32'h0,         32'h1234_5678, 5'd0, 1'b0, 4'h0,   32'h0,         32'h1234_5678, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 3'b001, 32'h0000_0102, 32'h0000_BEEF, 32'h0,        5'd0, 1'b0, 4'b1100, 32'hBEEF_BEEF, 32'h0,       1'b0};
    vecs[9]  = '{1'b1, 1'b1, 3'b010, 32'h0000_0100, 32'h0,         32'h0,         5'd1, 1'b1, 4'h0,   32'h0,         32'h0,         1'b0};
    vecs[10] = '{1'b0, 1'b0, 3'b010, 32'h0000_0100, 32'h0,         32'h0,         5'd1, 1'b1, 4'h0,   32'h0,         32'h0,         1'b0};
    vecs[11] = '{1'b0, 1'b1, 3'b100, 32'h0000_0100, 32'h0,         32'h0,         5'd1, 1'b1, 4'h0,   32'h0,         32'h0,         1'b0};
    vecs[12] = '{1'b1, 1'b0, 3'b011, 32'h0000_0100, 32'h0,         32'h0,         5'd1, 1'b1, 4'h0,   32'h0,         32'h0,         1'b0};
    vecs[13] = '{1'b1, 1'b0, 3'b001, 32'h0000_0201, 32'h0,         32'h0,         5'd1, 1'b1, 4'h0,   32'h0,         32'h0,         1'b0};
    vecs[14] = '{1'b1, 1'b0, 3'b000, 32'h0000_0101, 32'h0,         32'h0000_7F00, 5'd9, 1'b0, 4'h0,   32'h0,         32'h0000_007F, 1'b1};
    vecs[15] = '{1'b1, 1'b0, 3'b001, 32'h0000_0200, 32'h0,         32'h8001_1234, 5'd2, 1'b0, 4'h0,   32'h0,         32'h0000_1234, 1'b1};
    vecs[16] = '{1'b0, 1'b1, 3'b000, 32'h0000_0101, 32'h1234_5677, 32'h0,        5'd0, 1'b0, 4'b0010, 32'h7777_7777, 32'h0,       1'b0};

    RST = 1'b1; start = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; funct3 = 3'b000;
    ALUResult = 32'h0; RD2 = 32'h0; A3_in = 5'd0;
    bus.mem_ready = 1'b0; bus.mem_rdata = 32'h0;
    last_res = 32'h0;
    @(negedge CLK);
    @(negedge CLK);
    chk("reset_ctrl", {27'd0, busy, done, misaligned, bus.mem_req, RegWrite}, 32'd0);
    chk("reset_result", Result, 32'h0);
    chk("reset_bus", bus.mem_addr | bus.mem_wdata | {28'd0, bus.mem_wstrb} | {27'd0, A3_o}, 32'h0);
    RST = 1'b0;
    @(negedge CLK);

    for (int i = 0; i < 17; i++) begin
      run_vec(vecs[i], 0, 1'b0);
    end

    // Three wait states with a stray start while busy.
    run_vec(vecs[0], 3, 1'b1);
    run_vec(vecs[4], 2, 1'b0);

    // Reset while a load is waiting on memory.
    start = 1'b1; MemRead = 1'b1; MemWrite = 1'b0; funct3 = F3_W;
    ALUResult = 32'h0000_0400; A3_in = 5'd4;
    bus.mem_rdata = 32'hCAFE_F00D; bus.mem_ready = 1'b0;
    @(negedge CLK);
    start = 1'b0;
    @(negedge CLK);
    chk("rst_pre_req", {31'd0, bus.mem_req}, 32'd1);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    last_res = 32'h0;
    chk("rst_abort_ctrl", {29'd0, bus.mem_req, busy, done}, 32'd0);
    chk("rst_abort_result", Result, 32'h0);
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      chk("rst_no_done", {30'd0, done, busy}, 32'd0);
    end
    run_vec(vecs[5], 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Memory-side counterpart of the execute/register-file block: consumes its ALUResult (address), RD2 (store data) and destination register, and returns the Result and RegWrite it writes back.
- Performs one RV32I load or store per request over a simple req/ready memory handshake.
- Handles byte/half/word lane steering, write strobes, load sign/zero extension and misalignment detection.
- Sits between execute and the data memory in the multi-cycle datapath.

Parameters:
- A_WIDTH, 5, register address width.
- D_WIDTH, 32, data/address width; byte-lane logic is defined for 32 only.

Ports:
- CLK in 1: clock, rising edge.
- RST in 1: synchronous active-high reset.
- start in 1: issue request; sampled only in IDLE.
- MemRead in 1: load request.
- MemWrite in 1: store request.
- funct3 in 3: size/sign. 000 B, 001 H, 010 W, 100 BU, 101 HU (U variants are loads only).
- ALUResult in D_WIDTH: byte address.
- RD2 in D_WIDTH: store data.
- A3_in in A_WIDTH: load destination register.
- busy out 1: high in any state except IDLE.
- done out 1: one-cycle completion pulse.
- misaligned out 1: one-cycle pulse with done on an alignment or illegal-op fault.
- mem_req out 1: memory request.
- mem_we out 1: 1 = write.
- mem_addr out D_WIDTH: word-aligned address, {ALUResult[31:2],2'b00}.
- mem_wdata out D_WIDTH: lane-replicated store data.
- mem_wstrb out 4: byte write enables.
- mem_ready in 1: memory accepts/completes the request this cycle.
- mem_rdata in D_WIDTH: read word, valid when mem_ready && !mem_we.
- Result out D_WIDTH: formatted load data.
- RegWrite out 1: one-cycle write-back enable.
- A3 out A_WIDTH: write-back register address.

Behaviour:
- Reset: all outputs 0, state IDLE, captured registers 0. Reset mid-operation aborts at that edge; mem_req is low the following cycle and no done is issued.
- States: IDLE, REQ, WB, ERR. All outputs are registered or decoded from state only; no input-to-output combinational path except none.
- IDLE, start=1 at edge:
  - Capture address, funct3, RD2, A3_in and op.
  - Go to ERR if any of: MemRead&&MemWrite; neither set; H access with addr[0]=1; W access with addr[1:0]!=0; store with funct3 of 1xx or 011; load with funct3 of 011, 110 or 111.
  - Otherwise go to REQ.
- REQ:
  - mem_req=1. mem_we, mem_addr, mem_wdata and mem_wstrb are held stable until mem_ready.
  - On mem_ready: a load captures mem_rdata and goes to WB; a store goes to WB with RegWrite suppressed.
  - No timeout; waits indefinitely.
- WB (one cycle): done=1, and for loads Result=formatted data and RegWrite=(A3!=0). Then go to IDLE.
- ERR (one cycle): done=1, misaligned=1, RegWrite=0, no mem_req. Then go to IDLE.
- Latency: with start at edge 0 and mem_ready already high, mem_req is seen in cycle 1 and done in cycle 2. Each wait cycle on mem_ready adds one cycle.
- start while busy: ignored, not queued. start in the same cycle done is high is also ignored; the earliest re-issue is the cycle after done.
- Store steering, off = addr[1:0]:
  - SB: wdata={4{RD2[7:0]}}, wstrb=4'b0001<<off.
  - SH: wdata={2{RD2[15:0]}}, wstrb=4'b0011<<off.
  - SW: wdata=RD2, wstrb=4'hF.
- Load formatting:
  - byte = rdata[8*off+:8]; half = rdata[16*off[1]+:16].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- Result holds its last value outside WB. RegWrite is the only write qualifier.

Decomposition:
- Shared package mem_pkg holds:
  - enum mem_state_t {IDLE,REQ,WB,ERR};
  - funct3 localparams F3_B=3'b000, F3_H=3'b001, F3_W=3'b010, F3_BU=3'b100, F3_HU=3'b101.
- One natural combinational sub-module: load_formatter (funct3, off, rdata -> Result).
- Store steering and the FSM stay in mem_access_unit.

Test Plan:
- SW: addr 0x100, RD2 0xDEADBEEF, ready immediate -> mem_addr 0x100, wstrb F, wdata 0xDEADBEEF; done in cycle 2; RegWrite 0.
- SB: addr 0x103, RD2 0x000000A5 -> wstrb 4'b1000, wdata 0xA5A5A5A5. LB of the same address with rdata 0xA5000000 -> Result 0xFFFFFFA5. LBU -> 0x000000A5.
- LH: addr 0x202, rdata 0x8001_1234, A3 5 -> Result 0xFFFF8001, RegWrite 1, A3 5. LHU -> 0x00008001.
- LW: addr 0x302 -> ERR, done+misaligned pulse, mem_req never asserted. LW with A3=0 -> memory accessed, RegWrite 0.
- Wait states: mem_ready low for 3 cycles -> mem_req, addr and strobes stable for 4 cycles, done in cycle 5. start pulsed while busy -> ignored.
- RST asserted in REQ -> next cycle mem_req 0, busy 0, no done. A new start after reset completes normally.
